// File: rtl/composite_pkg.sv
// Shared constants, scanout state encoding and the accumulator-to-pixel helper
// for the composite line scanout slice.
package composite_pkg;

  localparam int H_ACTIVE    = 1280;
  localparam int LINE_PIXELS = 640;
  localparam int ADDR_W      = 10;
  localparam int FRAC_W      = 8;
  localparam int RGB_W       = 12;
  localparam int IDX_W       = 8;
  localparam int PAL_DEPTH   = 256;
  localparam int PAL_AW      = 8;
  localparam int ACC_W       = ADDR_W + FRAC_W;
  localparam int LINE_DEPTH  = 2 * LINE_PIXELS;
  localparam int LINE_AW     = $clog2(LINE_DEPTH);

  localparam logic [ADDR_W-1:0]  LAST_PIXEL = ADDR_W'(LINE_PIXELS - 1);
  localparam logic [LINE_AW-1:0] BANK1_BASE = LINE_AW'(LINE_PIXELS);

  typedef enum logic [1:0] {
    SCAN_IDLE,
    SCAN_PRIME,
    SCAN_READY,
    SCAN_ACTIVE
  } scan_state_t;

  // Integer part of the scaled position, clamped to the last stored pixel so
  // a saturated accumulator keeps showing the right-most pixel.
  function automatic logic [ADDR_W-1:0] acc_to_pixel(input logic [ACC_W-1:0] acc);
    logic [ADDR_W-1:0] whole;
    whole = acc[ACC_W-1:FRAC_W];
    return (whole > LAST_PIXEL) ? LAST_PIXEL : whole;
  endfunction

endpackage

// File: rtl/composite_dpram.sv
// Simple dual-port RAM: one write port, one registered read port with a read
// enable. A read and a write to the same word in one cycle return the old word.
module composite_dpram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_wr_en,
  input  logic [AW-1:0]     i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_en,
  input  logic [AW-1:0]     i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Write and registered read on the same edge; non-blocking update gives read-old-data.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    if (i_rd_en) o_rd_data <= r_mem[i_rd_addr];
  end

endmodule

// File: rtl/composite_line_scanout.sv
// Double-buffered line scanout: the renderer fills the back bank while the
// front bank is scanned through a 3-stage prefetch pipeline (address, line RAM,
// palette RAM) so the RGB for each active clock is ready when it is needed.
module composite_line_scanout
  import composite_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_next_pixel,
  input  logic              i_hblank_state,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [IDX_W-1:0]  i_wr_data,
  input  logic              i_render_done,
  output logic              o_render_req,
  input  logic              i_pal_wr_en,
  input  logic [PAL_AW-1:0] i_pal_wr_addr,
  input  logic [RGB_W-1:0]  i_pal_wr_data,
  input  logic [FRAC_W-1:0] i_hscale,
  input  logic [IDX_W-1:0]  i_border_color,
  output logic [RGB_W-1:0]  o_palette_rgb_data,
  output logic              o_underrun
);

  scan_state_t        r_state;
  logic [1:0]         r_prime_cnt;
  logic [ACC_W-1:0]   r_acc;
  logic [ADDR_W-1:0]  r_addr_a;
  logic               r_hblank_d;
  logic               r_front;
  logic               r_done;
  logic               r_line_bad;
  logic               r_render_req;
  logic               r_underrun;

  logic               w_swap;
  logic               w_pipe_en;
  logic               w_scanning;
  logic [ACC_W:0]     w_acc_sum;
  logic [ACC_W-1:0]   w_acc_next;
  logic               w_line_wr_en;
  logic [LINE_AW-1:0] w_line_wr_addr;
  logic [LINE_AW-1:0] w_line_rd_addr;
  logic [IDX_W-1:0]   w_line_q;
  logic [IDX_W-1:0]   w_pal_rd_idx;
  logic [RGB_W-1:0]   w_pal_q;

  // Swap edge, pipeline enable, saturating accumulator step and RAM addressing.
  always_comb begin
    w_swap         = i_hblank_state & ~r_hblank_d;
    w_scanning     = (r_state == SCAN_READY) || (r_state == SCAN_ACTIVE);
    w_pipe_en      = (r_state == SCAN_PRIME) || (w_scanning && i_next_pixel);
    w_acc_sum      = {1'b0, r_acc} + {{(ACC_W + 1 - FRAC_W){1'b0}}, i_hscale};
    w_acc_next     = w_acc_sum[ACC_W] ? {ACC_W{1'b1}} : w_acc_sum[ACC_W-1:0];
    w_line_wr_en   = i_wr_en && (i_wr_addr <= LAST_PIXEL);
    w_line_wr_addr = LINE_AW'(i_wr_addr);
    if (!r_front) w_line_wr_addr = w_line_wr_addr + BANK1_BASE;
    w_line_rd_addr = LINE_AW'(r_addr_a);
    if (r_front) w_line_rd_addr = w_line_rd_addr + BANK1_BASE;
    w_pal_rd_idx   = r_line_bad ? i_border_color : w_line_q;
  end

  // Line swap bookkeeping: bank toggle, render credit and the one-clock status pulses.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hblank_d   <= 1'b1;
      r_front      <= 1'b0;
      r_done       <= 1'b0;
      r_line_bad   <= 1'b0;
      r_render_req <= 1'b0;
      r_underrun   <= 1'b0;
    end else begin
      r_hblank_d   <= i_hblank_state;
      r_render_req <= w_swap;
      r_underrun   <= 1'b0;
      if (w_swap) begin
        r_front    <= ~r_front;
        r_line_bad <= ~(r_done | i_render_done);
        r_underrun <= ~(r_done | i_render_done);
        r_done     <= 1'b0;
      end else if (i_render_done) begin
        r_done <= 1'b1;
      end
    end
  end

  // Scanout sequencer: prime the pipeline after each swap, then follow next_pixel.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= SCAN_IDLE;
      r_prime_cnt <= 2'd0;
      r_acc       <= '0;
    end else if (w_swap) begin
      r_state     <= SCAN_PRIME;
      r_prime_cnt <= 2'd0;
      r_acc       <= '0;
    end else begin
      if (w_pipe_en) r_acc <= w_acc_next;
      case (r_state)
        SCAN_PRIME: begin
          if (r_prime_cnt == 2'd2) r_state <= SCAN_READY;
          else r_prime_cnt <= r_prime_cnt + 2'd1;
        end
        SCAN_READY: begin
          if (i_next_pixel) r_state <= SCAN_ACTIVE;
        end
        default: r_state <= r_state;
      endcase
    end
  end

  // Stage A: latch the clamped source pixel address for the clock being issued.
  always_ff @(posedge i_clk) begin
    if (w_pipe_en) r_addr_a <= acc_to_pixel(r_acc);
  end

  // Stage B: line buffer, both banks in one RAM with bank 1 offset by a line.
  composite_dpram #(
    .DATA_W (IDX_W),
    .DEPTH  (LINE_DEPTH),
    .AW     (LINE_AW)
  ) u_line_ram (
    .i_clk     (i_clk),
    .i_wr_en   (w_line_wr_en),
    .i_wr_addr (w_line_wr_addr),
    .i_wr_data (i_wr_data),
    .i_rd_en   (w_pipe_en),
    .i_rd_addr (w_line_rd_addr),
    .o_rd_data (w_line_q)
  );

  // Stage C: palette lookup whose registered output drives the pixel bus.
  composite_dpram #(
    .DATA_W (RGB_W),
    .DEPTH  (PAL_DEPTH),
    .AW     (PAL_AW)
  ) u_palette_ram (
    .i_clk     (i_clk),
    .i_wr_en   (i_pal_wr_en),
    .i_wr_addr (i_pal_wr_addr),
    .i_wr_data (i_pal_wr_data),
    .i_rd_en   (w_pipe_en),
    .i_rd_addr (w_pal_rd_idx),
    .o_rd_data (w_pal_q)
  );

  assign o_palette_rgb_data = w_scanning ? w_pal_q : '0;
  assign o_render_req       = r_render_req;
  assign o_underrun         = r_underrun;

endmodule
